// File: rtl/round_robin_arbiter4_if.sv
// Request/grant bundle between four requesters and the round-robin arbiter.
// The arbiter takes the slave side; the requester side (or a bench) takes master.
interface round_robin_arbiter4_if;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       valid;

  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_idx,
    output valid
  );

  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_idx,
    input  valid
  );
endinterface

// File: rtl/round_robin_arbiter4.sv
// Four-way round-robin arbiter with an optional hold limit per grant.
// Each owner keeps the grant until it signals done, drops its request, or times out.
module round_robin_arbiter4 #(
  parameter int unsigned MAX_HOLD = 0
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  round_robin_arbiter4_if.slave bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [7:0] HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_last;
  logic [1:0] w_last_nxt;
  logic [1:0] r_idx;
  logic [1:0] w_idx_nxt;
  logic [3:0] r_gnt;
  logic [3:0] w_gnt_nxt;
  logic [7:0] r_hold;
  logic [7:0] w_hold_nxt;
  logic       w_timeout;
  logic       w_release;

  // Scan last+1, last+2, last+3, last; the previous owner ranks lowest.
  function automatic logic [1:0] f_pick(input logic [3:0] req, input logic [1:0] last);
    logic       found;
    logic [1:0] cand;
    f_pick = last;
    found  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = last + k[1:0];
      if (!found && req[cand]) begin
        f_pick = cand;
        found  = 1'b1;
      end else begin
        found  = found;
      end
    end
  endfunction

  assign w_timeout = (MAX_HOLD != 0) && (r_hold == HOLD_LAST);
  assign w_release = bus.done || !bus.req[r_idx] || w_timeout;

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_idx_nxt   = r_idx;
    w_gnt_nxt   = r_gnt;
    w_hold_nxt  = r_hold;
    case (r_state)
      ST_IDLE: begin
        if (bus.req != 4'b0000) begin
          w_state_nxt = ST_BUSY;
          w_idx_nxt   = f_pick(bus.req, r_last);
          w_gnt_nxt   = 4'b0001 << f_pick(bus.req, r_last);
          w_hold_nxt  = 8'd0;
        end else begin
          w_state_nxt = ST_IDLE;
          w_idx_nxt   = 2'd0;
          w_gnt_nxt   = 4'b0000;
          w_hold_nxt  = 8'd0;
        end
      end
      ST_BUSY: begin
        if (w_release) begin
          // A single release point, so done plus timeout updates LAST once.
          w_state_nxt = ST_IDLE;
          w_last_nxt  = r_idx;
          w_idx_nxt   = 2'd0;
          w_gnt_nxt   = 4'b0000;
          w_hold_nxt  = 8'd0;
        end else begin
          w_hold_nxt  = r_hold + 8'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_last_nxt  = 2'd3;
        w_idx_nxt   = 2'd0;
        w_gnt_nxt   = 4'b0000;
        w_hold_nxt  = 8'd0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_last  <= 2'd3;
      r_idx   <= 2'd0;
      r_gnt   <= 4'b0000;
      r_hold  <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_idx   <= w_idx_nxt;
      r_gnt   <= w_gnt_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.gnt_idx = r_idx;
  assign bus.valid   = (r_state == ST_BUSY);

endmodule
